// File: rtl/msc_pkg.sv
// Shared definitions for the USB Mass Storage Bulk-Only Transport handler:
// wrapper signatures, FSM state codes and CSW status codes.
package msc_pkg;

  localparam logic [31:0] CBW_SIGNATURE = 32'h4342_5355;
  localparam logic [31:0] CSW_SIGNATURE = 32'h5342_5355;

  typedef enum logic [7:0] {
    ST_IDLE    = 8'd0,
    ST_CBW     = 8'd1,
    ST_CMD     = 8'd2,
    ST_EXEC    = 8'd3,
    ST_DATA_IN = 8'd4,
    ST_CSW     = 8'd5
  } msc_state_t;

  typedef enum logic [7:0] {
    CSW_PASSED      = 8'd0,
    CSW_FAILED      = 8'd1,
    CSW_PHASE_ERROR = 8'd2
  } csw_status_t;

  // Any non-GOOD SCSI status is reported to the host as a failed command.
  function automatic csw_status_t csw_status_code(input logic [7:0] scsi_status);
    return (scsi_status == 8'h00) ? CSW_PASSED : CSW_FAILED;
  endfunction

endpackage

// File: rtl/msc_protocol_if.sv
// Stream and command bus between the BBB handler, the USB bulk endpoints
// and the SCSI command engine. The slave view is the handler itself.
interface msc_protocol_if;

  logic [31:0]  usb_rx_data;
  logic         usb_rx_valid;
  logic         usb_rx_ready;

  logic [31:0]  usb_tx_data;
  logic         usb_tx_valid;
  logic         usb_tx_ready;

  logic [127:0] scsi_cdb;
  logic [7:0]   scsi_cdb_length;
  logic [2:0]   scsi_lun;
  logic [31:0]  scsi_transfer_length;
  logic         scsi_data_in;
  logic         scsi_valid;
  logic         scsi_ready;
  logic         scsi_done;
  logic [7:0]   scsi_status;

  logic [31:0]  data_out;
  logic         data_out_valid;
  logic         data_out_ready;

  logic [31:0]  data_in;
  logic         data_in_valid;
  logic         data_in_ready;

  modport slave (
    input  usb_rx_data, usb_rx_valid, usb_tx_ready,
    input  scsi_ready, scsi_done, scsi_status,
    input  data_out_ready, data_in, data_in_valid,
    output usb_rx_ready, usb_tx_data, usb_tx_valid,
    output scsi_cdb, scsi_cdb_length, scsi_lun, scsi_transfer_length,
    output scsi_data_in, scsi_valid,
    output data_out, data_out_valid, data_in_ready
  );

  modport master (
    output usb_rx_data, usb_rx_valid, usb_tx_ready,
    output scsi_ready, scsi_done, scsi_status,
    output data_out_ready, data_in, data_in_valid,
    input  usb_rx_ready, usb_tx_data, usb_tx_valid,
    input  scsi_cdb, scsi_cdb_length, scsi_lun, scsi_transfer_length,
    input  scsi_data_in, scsi_valid,
    input  data_out, data_out_valid, data_in_ready
  );

endinterface

// File: rtl/msc_cbw_parser.sv
// Collects the eight CBW words, validates the wrapper on the last word and
// latches the command fields only when the wrapper is valid.
module msc_cbw_parser
  import msc_pkg::*;
#(
  parameter int MAX_LUNS         = 4,
  parameter int MAX_SECTOR_COUNT = 128,
  parameter int SECTOR_SIZE      = 512
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  word,
  input  logic         accept,
  output logic         last,
  output logic         ok,
  output logic [31:0]  tag,
  output logic [31:0]  length,
  output logic [127:0] cdb,
  output logic [7:0]   cdb_length,
  output logic [2:0]   lun,
  output logic         data_in,
  output logic         cbw_valid,
  output logic         cbw_error
);

  localparam logic [31:0] MAX_BYTES = 32'(MAX_SECTOR_COUNT * SECTOR_SIZE);
  localparam logic [7:0]  LUN_LIMIT = 8'(MAX_LUNS);

  logic [2:0]   cnt;
  logic         sig_ok;
  logic [31:0]  tag_s, len_s, w3_s, w4_s, w5_s, w6_s;
  logic [127:0] cdb_raw, cdb_masked;
  logic         fields_ok;

  // Word position within the wrapper; wraps to 0 after the eighth word.
  always_ff @(posedge clk) begin
    if (rst) cnt <= 3'd0;
    else if (accept) cnt <= cnt + 3'd1;
  end

  // Staging of words 0..6; word 7 is consumed directly on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      case (cnt)
        3'd0:    sig_ok <= (word == CBW_SIGNATURE);
        3'd1:    tag_s  <= word;
        3'd2:    len_s  <= word;
        3'd3:    w3_s   <= word;
        3'd4:    w4_s   <= word;
        3'd5:    w5_s   <= word;
        3'd6:    w6_s   <= word;
        default: ;
      endcase
    end
  end

  // Validation and CDB assembly; bytes beyond the declared length read as zero.
  always_comb begin
    fields_ok = sig_ok
             && (w3_s[15:8] < LUN_LIMIT)
             && (w3_s[23:16] >= 8'd1) && (w3_s[23:16] <= 8'd16)
             && (len_s <= MAX_BYTES);
    last    = accept && (cnt == 3'd7);
    ok      = last && fields_ok;
    cdb_raw = {word[23:0], w6_s, w5_s, w4_s, w3_s[31:24]};
    cdb_masked = '0;
    for (int i = 0; i < 16; i++) begin
      if (8'(i) < w3_s[23:16]) cdb_masked[8*i +: 8] = cdb_raw[8*i +: 8];
    end
  end

  // Command fields seen by the SCSI engine change only on a valid wrapper.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag        <= '0;
      length     <= '0;
      cdb        <= '0;
      cdb_length <= '0;
      lun        <= '0;
      data_in    <= 1'b0;
    end else if (ok) begin
      tag        <= tag_s;
      length     <= len_s;
      cdb        <= cdb_masked;
      cdb_length <= w3_s[23:16];
      lun        <= w3_s[10:8];
      data_in    <= w3_s[7];
    end
  end

  // Accept pulse and sticky error flag, cleared by the next wrapper's first word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cbw_valid <= 1'b0;
      cbw_error <= 1'b0;
    end else begin
      cbw_valid <= ok;
      if (last && !ok) cbw_error <= 1'b1;
      else if (accept && (cnt == 3'd0)) cbw_error <= 1'b0;
    end
  end

endmodule

// File: rtl/msc_protocol.sv
// Bulk-Only Transport protocol handler: CBW intake, SCSI command hand-off,
// data phase relay and CSW return.
module msc_protocol
  import msc_pkg::*;
#(
  parameter int MAX_LUNS         = 4,
  parameter int MAX_SECTOR_COUNT = 128,
  parameter int SECTOR_SIZE      = 512
) (
  input  logic           clk,
  input  logic           rst,
  msc_protocol_if.slave  bus,
  output logic [7:0]     msc_state,
  output logic           cbw_valid,
  output logic           cbw_error
);

  msc_state_t   state, state_nx;
  logic         alive;
  logic [31:0]  moved;
  logic [7:0]   status_q;
  logic [1:0]   csw_idx;

  logic         cbw_phase, cbw_accept, cbw_last, cbw_ok;
  logic [31:0]  cmd_tag, cmd_length;
  logic [127:0] cmd_cdb;
  logic [7:0]   cmd_cdb_length;
  logic [2:0]   cmd_lun;
  logic         cmd_data_in;

  logic [31:0]  remain, step, csw_word;
  logic         out_window, in_window, out_xfer, in_xfer, csw_xfer;

  msc_cbw_parser #(
    .MAX_LUNS         (MAX_LUNS),
    .MAX_SECTOR_COUNT (MAX_SECTOR_COUNT),
    .SECTOR_SIZE      (SECTOR_SIZE)
  ) u_parser (
    .clk        (clk),
    .rst        (rst),
    .word       (bus.usb_rx_data),
    .accept     (cbw_accept),
    .last       (cbw_last),
    .ok         (cbw_ok),
    .tag        (cmd_tag),
    .length     (cmd_length),
    .cdb        (cmd_cdb),
    .cdb_length (cmd_cdb_length),
    .lun        (cmd_lun),
    .data_in    (cmd_data_in),
    .cbw_valid  (cbw_valid),
    .cbw_error  (cbw_error)
  );

  assign bus.scsi_cdb             = cmd_cdb;
  assign bus.scsi_cdb_length      = cmd_cdb_length;
  assign bus.scsi_lun             = cmd_lun;
  assign bus.scsi_transfer_length = cmd_length;
  assign bus.scsi_data_in         = cmd_data_in;
  assign msc_state                = state;

  // Holds the OUT stream off until the first cycle after reset is released.
  always_ff @(posedge clk) begin
    if (rst) alive <= 1'b0;
    else     alive <= 1'b1;
  end

  // Protocol state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Byte accounting and data-phase windows; a word never counts past the length.
  always_comb begin
    remain     = cmd_length - moved;
    step       = (remain > 32'd4) ? 32'd4 : remain;
    cbw_phase  = alive && ((state == ST_IDLE) || (state == ST_CBW));
    cbw_accept = cbw_phase && bus.usb_rx_valid;
    out_window = (state == ST_EXEC) && !cmd_data_in && (moved < cmd_length);
    in_window  = (state == ST_DATA_IN) && (moved < cmd_length);
    out_xfer   = out_window && bus.usb_rx_valid && bus.data_out_ready;
    in_xfer    = in_window && bus.data_in_valid && bus.usb_tx_ready;
    csw_xfer   = (state == ST_CSW) && bus.usb_tx_ready;
    case (csw_idx)
      2'd0:    csw_word = CSW_SIGNATURE;
      2'd1:    csw_word = cmd_tag;
      2'd2:    csw_word = remain;
      default: csw_word = {24'h0, csw_status_code(status_q)};
    endcase
  end

  // Next-state decisions; completion in CMD is deliberately ignored.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (cbw_accept) state_nx = ST_CBW;
      ST_CBW:     if (cbw_last) state_nx = cbw_ok ? ST_CMD : ST_IDLE;
      ST_CMD:     if (bus.scsi_ready) state_nx = ST_EXEC;
      ST_EXEC: begin
        if (bus.scsi_done) begin
          if (cmd_data_in && (cmd_length != 32'd0) && (bus.scsi_status == 8'h00))
            state_nx = ST_DATA_IN;
          else
            state_nx = ST_CSW;
        end
      end
      ST_DATA_IN: if (!in_window || (in_xfer && (step == remain))) state_nx = ST_CSW;
      ST_CSW:     if (csw_xfer && (csw_idx == 2'd3)) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Handshake and stream routing for the current phase.
  always_comb begin
    bus.usb_rx_ready   = 1'b0;
    bus.usb_tx_valid   = 1'b0;
    bus.usb_tx_data    = '0;
    bus.scsi_valid     = 1'b0;
    bus.data_out       = '0;
    bus.data_out_valid = 1'b0;
    bus.data_in_ready  = 1'b0;
    if (cbw_phase) bus.usb_rx_ready = 1'b1;
    if (state == ST_CMD) bus.scsi_valid = 1'b1;
    if (out_window) begin
      bus.data_out       = bus.usb_rx_data;
      bus.data_out_valid = bus.usb_rx_valid;
      bus.usb_rx_ready   = bus.data_out_ready;
    end
    if (in_window) begin
      bus.usb_tx_data   = bus.data_in;
      bus.usb_tx_valid  = bus.data_in_valid;
      bus.data_in_ready = bus.usb_tx_ready;
    end
    if (state == ST_CSW) begin
      bus.usb_tx_data  = csw_word;
      bus.usb_tx_valid = 1'b1;
    end
  end

  // Bytes moved in the current command, restarted while the command is offered.
  always_ff @(posedge clk) begin
    if (rst) moved <= '0;
    else if (state == ST_CMD) moved <= '0;
    else if (out_xfer || in_xfer) moved <= moved + step;
  end

  // SCSI status captured on completion for the CSW.
  always_ff @(posedge clk) begin
    if (rst) status_q <= '0;
    else if ((state == ST_EXEC) && bus.scsi_done) status_q <= bus.scsi_status;
  end

  // CSW word index, advanced on each IN handshake.
  always_ff @(posedge clk) begin
    if (rst || (state != ST_CSW)) csw_idx <= 2'd0;
    else if (csw_xfer) csw_idx <= csw_idx + 2'd1;
  end

endmodule

// File: tb/tb_msc_protocol.sv
// Directed testbench for msc_protocol: BBB command sequences with
// hand-computed CSW contents and handshake expectations.
module tb_msc_protocol;
  import msc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] msc_state;
  logic       cbw_valid, cbw_error;
  int         checks = 0;
  int         errors = 0;

  msc_protocol_if bus();

  msc_protocol dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .msc_state (msc_state),
    .cbw_valid (cbw_valid),
    .cbw_error (cbw_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_rx(input logic [31:0] w);
    bus.usb_rx_data  = w;
    bus.usb_rx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.usb_rx_ready) break;
    end
    if (!bus.usb_rx_ready) check_val("rx_handshake", 128'(bus.usb_rx_ready), 128'(1'b1));
    @(posedge clk); #1;
    bus.usb_rx_valid = 1'b0;
  endtask

  task automatic send_cbw(input logic [31:0] sig, input logic [31:0] tag, input logic [31:0] len,
                          input logic [7:0] flags, input logic [7:0] lun, input logic [7:0] clen,
                          input logic [127:0] cdb);
    logic [31:0] w [8];
    w[0] = sig;
    w[1] = tag;
    w[2] = len;
    w[3] = {cdb[7:0], clen, lun, flags};
    w[4] = cdb[39:8];
    w[5] = cdb[71:40];
    w[6] = cdb[103:72];
    w[7] = {8'hEE, cdb[127:104]};
    for (int i = 0; i < 8; i++) send_rx(w[i]);
  endtask

  task automatic issue_cmd();
    bus.scsi_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.scsi_valid) break;
    end
    check_val("cmd_offered", 128'(bus.scsi_valid), 128'(1'b1));
    @(posedge clk); #1;
    bus.scsi_ready = 1'b0;
  endtask

  task automatic finish_cmd(input logic [7:0] st);
    bus.scsi_status = st;
    bus.scsi_done   = 1'b1;
    @(posedge clk); #1;
    bus.scsi_done   = 1'b0;
  endtask

  task automatic recv_csw(input string name, input logic [31:0] tag, input logic [31:0] residue,
                          input logic [7:0] status);
    logic [31:0] exp [4];
    exp[0] = 32'h5342_5355;
    exp[1] = tag;
    exp[2] = residue;
    exp[3] = {24'h0, status};
    for (int k = 0; k < 4; k++) begin
      bus.usb_tx_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.usb_tx_valid) break;
      end
      check_val($sformatf("%s_csw%0d", name, k), 128'(bus.usb_tx_data), 128'(exp[k]));
      @(posedge clk); #1;
      bus.usb_tx_ready = 1'b0;
    end
    check_val({name, "_back_idle"}, 128'(msc_state), 128'(8'd0));
  endtask

  task automatic relay_in(input string name, input int n, input logic [31:0] base);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      bus.data_in       = base + 32'(k);
      bus.data_in_valid = 1'b1;
      bus.usb_tx_ready  = 1'b1;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.data_in_ready) break;
      end
      if (!bus.data_in_ready || !bus.usb_tx_valid || (bus.usb_tx_data !== base + 32'(k))) bad++;
      @(posedge clk); #1;
    end
    bus.data_in_valid = 1'b0;
    bus.usb_tx_ready  = 1'b0;
    check_val({name, "_in_words"}, 128'(bad), 128'(0));
  endtask

  task automatic relay_out(input string name, input int n, input logic [31:0] base);
    int bad = 0;
    bus.data_out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      bus.usb_rx_data  = base + 32'(k);
      bus.usb_rx_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.usb_rx_ready) break;
      end
      if (!bus.usb_rx_ready || !bus.data_out_valid || (bus.data_out !== base + 32'(k))) bad++;
      @(posedge clk); #1;
    end
    bus.usb_rx_valid = 1'b0;
    check_val({name, "_out_words"}, 128'(bad), 128'(0));
    @(negedge clk);
    check_val({name, "_out_closed"}, 128'(bus.usb_rx_ready), 128'(1'b0));
    @(posedge clk); #1;
    bus.data_out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] cdb_raw, cdb_exp;
    bus.usb_rx_data = '0;    bus.usb_rx_valid = 1'b0;  bus.usb_tx_ready = 1'b0;
    bus.scsi_ready = 1'b0;   bus.scsi_done = 1'b0;     bus.scsi_status = '0;
    bus.data_out_ready = 1'b0; bus.data_in = '0;       bus.data_in_valid = 1'b0;
    rst = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_state",    128'(msc_state), 128'(8'd0));
    check_val("rst_cbw_valid", 128'(cbw_valid), 128'(1'b0));
    check_val("rst_cbw_error", 128'(cbw_error), 128'(1'b0));
    check_val("rst_scsi_valid", 128'(bus.scsi_valid), 128'(1'b0));
    check_val("rst_tx_valid", 128'(bus.usb_tx_valid), 128'(1'b0));
    check_val("rst_rx_ready", 128'(bus.usb_rx_ready), 128'(1'b0));
    check_val("rst_cdb",      bus.scsi_cdb, 128'(0));
    check_val("rst_cdb_len",  128'(bus.scsi_cdb_length), 128'(8'd0));
    check_val("rst_lun",      128'(bus.scsi_lun), 128'(3'd0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("rx_ready_after_rst", 128'(bus.usb_rx_ready), 128'(1'b1));

    // TEST UNIT READY
    send_cbw(CBW_SIGNATURE, 32'd1, 32'd0, 8'h00, 8'd0, 8'd6, 128'(0));
    check_val("tur_cbw_valid", 128'(cbw_valid), 128'(1'b1));
    check_val("tur_scsi_valid", 128'(bus.scsi_valid), 128'(1'b1));
    check_val("tur_state_cmd", 128'(msc_state), 128'(8'd2));
    finish_cmd(8'h00);
    check_val("tur_done_in_cmd_ignored", 128'(msc_state), 128'(8'd2));
    issue_cmd();
    check_val("tur_state_exec", 128'(msc_state), 128'(8'd3));
    check_val("tur_cdb_len", 128'(bus.scsi_cdb_length), 128'(8'd6));
    check_val("tur_cbw_valid_pulse", 128'(cbw_valid), 128'(1'b0));
    finish_cmd(8'h00);
    check_val("tur_state_csw", 128'(msc_state), 128'(8'd5));
    @(negedge clk);
    check_val("tur_csw_valid", 128'(bus.usb_tx_valid), 128'(1'b1));
    @(negedge clk);
    check_val("tur_csw_hold", 128'(bus.usb_tx_data), 128'(32'h5342_5355));
    @(posedge clk); #1;
    recv_csw("tur", 32'd1, 32'd0, 8'd0);

    // INQUIRY: CDB byte 10 lies beyond cdb_len 6 and must read back as zero
    cdb_raw = '0;
    cdb_raw[7:0] = 8'h12; cdb_raw[39:32] = 8'h24; cdb_raw[87:80] = 8'h55;
    cdb_exp = '0;
    cdb_exp[7:0] = 8'h12; cdb_exp[39:32] = 8'h24;
    send_cbw(CBW_SIGNATURE, 32'd2, 32'd36, 8'h80, 8'd0, 8'd6, cdb_raw);
    issue_cmd();
    check_val("inq_cdb", bus.scsi_cdb, cdb_exp);
    check_val("inq_data_in", 128'(bus.scsi_data_in), 128'(1'b1));
    check_val("inq_xfer_len", 128'(bus.scsi_transfer_length), 128'(32'd36));
    finish_cmd(8'h00);
    check_val("inq_state_data_in", 128'(msc_state), 128'(8'd4));
    relay_in("inq", 9, 32'hA000_0000);
    check_val("inq_state_csw", 128'(msc_state), 128'(8'd5));
    recv_csw("inq", 32'd2, 32'd0, 8'd0);

    // READ_10 on the highest legal LUN
    cdb_raw = '0;
    cdb_raw[7:0] = 8'h28; cdb_raw[71:64] = 8'h01;
    send_cbw(CBW_SIGNATURE, 32'd3, 32'd512, 8'h80, 8'd3, 8'd10, cdb_raw);
    issue_cmd();
    check_val("rd_lun", 128'(bus.scsi_lun), 128'(3'd3));
    check_val("rd_cdb", bus.scsi_cdb, cdb_raw);
    finish_cmd(8'h00);
    relay_in("rd", 128, 32'h0000_1000);
    recv_csw("rd", 32'd3, 32'd0, 8'd0);

    // Bad signature: no command, no CSW
    send_cbw(32'hBADC_0FFE, 32'd4, 32'd0, 8'h00, 8'd0, 8'd6, 128'(0));
    check_val("bad_sig_error", 128'(cbw_error), 128'(1'b1));
    check_val("bad_sig_state", 128'(msc_state), 128'(8'd0));
    check_val("bad_sig_no_valid", 128'(cbw_valid), 128'(1'b0));
    repeat (3) @(negedge clk);
    check_val("bad_sig_no_cmd", 128'(bus.scsi_valid), 128'(1'b0));
    check_val("bad_sig_no_csw", 128'(bus.usb_tx_valid), 128'(1'b0));
    @(posedge clk); #1;

    // WRITE_10 without OUT data: full residue
    cdb_raw = '0;
    cdb_raw[7:0] = 8'h2A; cdb_raw[71:64] = 8'h01;
    send_cbw(CBW_SIGNATURE, 32'd5, 32'd512, 8'h00, 8'd0, 8'd10, cdb_raw);
    check_val("wr_error_cleared", 128'(cbw_error), 128'(1'b0));
    check_val("wr_cbw_valid", 128'(cbw_valid), 128'(1'b1));
    issue_cmd();
    check_val("wr_data_in", 128'(bus.scsi_data_in), 128'(1'b0));
    finish_cmd(8'h00);
    recv_csw("wr0", 32'd5, 32'd512, 8'd0);

    // WRITE_10 with all 128 OUT words
    send_cbw(CBW_SIGNATURE, 32'd5, 32'd512, 8'h00, 8'd0, 8'd10, cdb_raw);
    issue_cmd();
    relay_out("wr128", 128, 32'h5000_0000);
    finish_cmd(8'h00);
    recv_csw("wr128", 32'd5, 32'd0, 8'd0);

    // WRITE_10 completing with CHECK CONDITION
    send_cbw(CBW_SIGNATURE, 32'd5, 32'd512, 8'h00, 8'd0, 8'd10, cdb_raw);
    issue_cmd();
    finish_cmd(8'h02);
    recv_csw("wrfail", 32'd5, 32'd512, 8'd1);

    // Field validation boundaries
    send_cbw(CBW_SIGNATURE, 32'd7, 32'd0, 8'h00, 8'd4, 8'd6, 128'(0));
    check_val("lun4_error", 128'(cbw_error), 128'(1'b1));
    send_cbw(CBW_SIGNATURE, 32'd7, 32'd0, 8'h00, 8'd0, 8'd0, 128'(0));
    check_val("cdblen0_error", 128'(cbw_error), 128'(1'b1));
    send_cbw(CBW_SIGNATURE, 32'd7, 32'd0, 8'h00, 8'd0, 8'd17, 128'(0));
    check_val("cdblen17_error", 128'(cbw_error), 128'(1'b1));
    send_cbw(CBW_SIGNATURE, 32'd7, 32'd65537, 8'h80, 8'd0, 8'd10, 128'(0));
    check_val("len65537_error", 128'(cbw_error), 128'(1'b1));
    check_val("len65537_state", 128'(msc_state), 128'(8'd0));

    // Largest legal length, failed data-in command skips the data phase
    send_cbw(CBW_SIGNATURE, 32'd9, 32'd65536, 8'h80, 8'd0, 8'd16, 128'(0));
    check_val("len65536_valid", 128'(cbw_valid), 128'(1'b1));
    issue_cmd();
    finish_cmd(8'h02);
    check_val("len65536_to_csw", 128'(msc_state), 128'(8'd5));
    recv_csw("len65536", 32'd9, 32'd65536, 8'd1);

    // Short final word: 6 bytes over two OUT words
    send_cbw(CBW_SIGNATURE, 32'd10, 32'd6, 8'h00, 8'd0, 8'd10, cdb_raw);
    issue_cmd();
    relay_out("wr6", 2, 32'h6000_0000);
    finish_cmd(8'h00);
    recv_csw("wr6", 32'd10, 32'd0, 8'd0);

    // Reset in the middle of a CBW abandons it
    send_rx(CBW_SIGNATURE);
    send_rx(32'd77);
    send_rx(32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("midrst_state", 128'(msc_state), 128'(8'd0));
    send_cbw(CBW_SIGNATURE, 32'd11, 32'd0, 8'h00, 8'd1, 8'd6, 128'(0));
    check_val("midrst_cbw_valid", 128'(cbw_valid), 128'(1'b1));
    issue_cmd();
    finish_cmd(8'h00);
    recv_csw("midrst", 32'd11, 32'd0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msc_protocol.md
# msc_protocol

USB Mass Storage Class Bulk-Only Transport (BBB) protocol handler, placed between the USB bulk endpoint word streams and the SCSI command engine. It collects a 31-byte CBW from the OUT stream, validates it and hands the CDB to the SCSI engine. It then relays the data phase and returns a 13-byte CSW on the IN stream. All streams are 32-bit words with little-endian byte packing.

## Interface
- MAX_LUNS, 4: LUNs accepted; LUN ≥ MAX_LUNS is invalid.
- MAX_SECTOR_COUNT, 128: with SECTOR_SIZE, bounds dCBWDataTransferLength.
- SECTOR_SIZE, 512: bytes per sector.

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- usb_rx_data / usb_rx_valid / usb_rx_ready  in/in/out  32/1/1  host OUT stream
- usb_tx_data / usb_tx_valid / usb_tx_ready  out/out/in  32/1/1  host IN stream
- scsi_cdb  out  128  CDB, byte i at [8i+7:8i], unused bytes zero
- scsi_cdb_length  out  8  bCBWCBLength
- scsi_lun  out  3  bCBWLUN[2:0]
- scsi_transfer_length  out  32  dCBWDataTransferLength
- scsi_data_in  out  1  bmCBWFlags[7] (1 = device-to-host)
- scsi_valid / scsi_ready  out/in  1/1  command handshake
- scsi_done / scsi_status  in/in  1/8  completion pulse and SCSI status
- data_out / data_out_valid / data_out_ready  out/out/in  32/1/1  write data to engine
- data_in / data_in_valid / data_in_ready  in/in/out  32/1/1  read data from engine
- msc_state  out  8  current state code
- cbw_valid  out  1  one-cycle pulse when a valid CBW is accepted
- cbw_error  out  1  invalid-CBW flag

## Operation
- CBW word layout: w0 signature 0x43425355, w1 tag, w2 transfer length, w3 {CDB0, cdb_len, lun, flags} (flags in [7:0]), w4–w7 CDB1..CDB15 packed in order, byte 31 ignored.
- States (msc_state): IDLE=0, CBW=1, CMD=2, EXEC=3, DATA_IN=4, CSW=5.
- IDLE/CBW: usb_rx_ready=1. Accept 8 words. After w7, validate: signature, LUN < MAX_LUNS, 1 ≤ cdb_len ≤ 16, length ≤ MAX_SECTOR_COUNT*SECTOR_SIZE.
  - Valid: latch fields, pulse cbw_valid, go to CMD.
  - Invalid: set cbw_error, go to IDLE, issue no command and no CSW.
- cbw_error clears when w0 of the next CBW is accepted.
- CMD: scsi_valid=1 until scsi_valid&scsi_ready, then EXEC.
- EXEC: wait for scsi_done and latch scsi_status.
  - For data-out commands with length > 0 and bytes moved < length, pass usb_rx through to data_out combinationally: data_out_valid=usb_rx_valid, usb_rx_ready=data_out_ready.
  - On scsi_done: go to DATA_IN if the command is data-in, length > 0 and status == 0. Otherwise go to CSW.
- DATA_IN: pass data_in through to usb_tx combinationally: data_in_ready=usb_tx_ready. Leave when moved bytes reach length, then go to CSW.
- Byte counting: each transferred word adds min(4, length − moved).
- Residue = length − moved, 32-bit, never negative.
- CSW: 4 words: 0x53425355, tag, residue, {24'h0, status}. Status = 0 if scsi_status == 0, else 1. Return to IDLE after word 3 handshakes.
- Words arriving on usb_rx outside IDLE/CBW and outside an EXEC data-out window are not accepted (ready=0).

## Timing
- Reset values: all handshake outputs 0, cbw_valid=0, cbw_error=0, msc_state=IDLE, CDB/length/LUN registers 0, usb_rx_ready=1 one cycle after reset is released.
- Transfer rate: one word per cycle when valid&ready.
- Command latency: scsi_valid rises the cycle after w7 is accepted.
- CSW latency: usb_tx_valid rises the cycle after entering CSW. usb_tx_data is stable while valid && !ready.
- scsi_done seen in CMD is ignored. If scsi_done and a data word arrive in the same cycle, the word is counted first.
- rst mid-transfer returns to IDLE immediately, abandoning the CBW/CSW.

## Structure
- Shared package msc_pkg: CBW/CSW signatures, state codes, CSW status codes (PASSED=0, FAILED=1, PHASE_ERROR=2, reserved).
- One natural sub-module: msc_cbw_parser (word collection plus validation, outputs latched fields and a valid/error pulse). FSM and data relay live in the top level.

## Test plan
- TEST UNIT READY: tag 1, length 0, CDB 0x00, status 0 -> scsi_valid, then CSW {0x53425355, 1, 0, 0}.
- INQUIRY: tag 2, length 36, flags 0x80, CDB[0]=0x12, CDB[4]=36, 9 data_in words -> 9 words on usb_tx, then CSW residue 0, status 0.
- READ_10: tag 3, length 512, CDB 0x28, 128 data words -> CSW tag 3, residue 0, status 0.
- Bad signature 0xBADC0FFE + 7 words -> cbw_error=1, no scsi_valid, no CSW. Next valid CBW clears cbw_error.
- WRITE_10: tag 5, length 512, no OUT data, done status 0 -> CSW residue 512, status 0. Repeat with 128 OUT words -> residue 0. Repeat with status 2 -> CSW status 1.
